// File: rtl/uart_rx_controller_pkg.sv
// Shared definitions for the UART receive path: state encoding, field widths
// and the oversample divider calculation.
package uart_rx_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  localparam int TICK_W = 4;
  localparam int DATA_W = 8;
  localparam int BIT_W  = $clog2(DATA_W);

  // 16x oversample divider, truncated, never below 1.
  function automatic int calc_div(input int clk_freq, input int baud);
    int raw;
    raw = clk_freq / (baud * 16);
    return (raw < 1) ? 1 : raw;
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Oversample tick generator: one-cycle pulse every DIV sysclk cycles,
// restarted by clr so the first tick lands DIV cycles after clr drops.
module uart_tick_gen
  import uart_rx_controller_pkg::*;
#(
  parameter int DIV = 651
) (
  input  logic sysclk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LOAD = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    if (clr || (cnt_q == '0)) cnt_d = LOAD;
    else                      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge sysclk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick = !clr && (cnt_q == '0);

endmodule

// File: rtl/uart_rx_controller.sv
// 8N1 UART receiver with 16x oversampling, a single-byte holding register
// and sticky frame-error / overrun flags acknowledged by rd_en.
module uart_rx_controller
  import uart_rx_controller_pkg::*;
#(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 9600
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              UART_RX,
  input  logic              rx_enable,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err,
  output logic              overrun,
  output logic              irq
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD);
  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(7);
  localparam logic [TICK_W-1:0] TICK_LAST = '1;
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  rx_state_e          state_q, state_d;
  logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]   bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [DATA_W-1:0]  rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               frame_err_q, frame_err_d;
  logic               overrun_q, overrun_d;
  logic               armed_q, armed_d;
  logic               sync1_q, sync2_q;
  logic               rx_sync, tick, stop_hit;

  assign rx_sync = sync2_q;

  uart_tick_gen #(.DIV(DIV)) u_tick_gen (
    .sysclk (sysclk),
    .reset  (reset),
    .clr    (state_q == ST_IDLE),
    .tick   (tick)
  );

  always_ff @(posedge sysclk) begin
    if (!reset) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= ST_IDLE;
      tick_cnt_q  <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      armed_q     <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= UART_RX;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      armed_q     <= armed_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    armed_d    = 1'b0;
    stop_hit   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        tick_cnt_d = '0;
        bit_idx_d  = '0;
        shift_d    = '0;
        // A start needs the line to have been seen high while idle.
        armed_d    = armed_q | rx_sync;
        if (rx_enable && armed_q && !rx_sync) begin
          state_d = ST_START;
          armed_d = 1'b0;
        end
      end
      ST_START: begin
        if (tick) begin
          if (tick_cnt_q == TICK_MID) begin
            tick_cnt_d = '0;
            state_d    = rx_sync ? ST_IDLE : ST_DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          tick_cnt_d = tick_cnt_q + 1'b1;
          if (tick_cnt_q == TICK_LAST) begin
            shift_d   = {rx_sync, shift_q[DATA_W-1:1]};
            bit_idx_d = bit_idx_q + 1'b1;
            if (bit_idx_q == BIT_LAST) state_d = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          tick_cnt_d = tick_cnt_q + 1'b1;
          if (tick_cnt_q == TICK_LAST) begin
            state_d  = ST_IDLE;
            stop_hit = 1'b1;
          end
        end
      end
    endcase
    if (state_q != ST_IDLE && !rx_enable) begin
      state_d    = ST_IDLE;
      tick_cnt_d = '0;
      bit_idx_d  = '0;
      shift_d    = '0;
      stop_hit   = 1'b0;
    end
  end

  always_comb begin
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q & ~rd_en;
    frame_err_d = frame_err_q & ~rd_en;
    overrun_d   = overrun_q & ~rd_en;
    if (stop_hit) begin
      if (rx_sync) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
        if (rx_valid_q && !rd_en) overrun_d = 1'b1;
      end else begin
        frame_err_d = 1'b1;
      end
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign irq       = rx_valid_q | frame_err_q | overrun_q;

endmodule

// File: tb/tb_uart_rx_controller.sv
// Directed bench for uart_rx_controller with DIV=4 (64 sysclk per bit).
module tb_uart_rx_controller;

  logic       sysclk = 1'b0;
  logic       reset;
  logic       UART_RX;
  logic       rx_enable;
  logic       rd_en;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       irq;

  int   n_vec = 0;
  int   n_err = 0;
  logic v_before, v_after;

  always #5 sysclk = ~sysclk;

  uart_rx_controller #(.CLK_FREQ(614400), .BAUD(9600)) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .UART_RX   (UART_RX),
    .rx_enable (rx_enable),
    .rd_en     (rd_en),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .irq       (irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  task automatic pulse_rd();
    rd_en = 1'b1;
    @(posedge sysclk);
    #1;
    rd_en = 1'b0;
  endtask

  // Frame starts at cycle 0; stop sample lands on the edge ending cycle 610.
  task automatic send(input logic [7:0] b, input logic stop, input int ncyc, input int rd_at);
    v_before = 1'bx;
    v_after  = 1'bx;
    for (int c = 0; c < ncyc; c++) begin
      if (c < 64)       UART_RX = 1'b0;
      else if (c < 576) UART_RX = b[(c - 64) / 64];
      else              UART_RX = stop;
      rd_en = (c == rd_at);
      @(posedge sysclk);
      #1;
      if (c == 609) v_before = rx_valid;
      if (c == 610) v_after  = rx_valid;
    end
    rd_en = 1'b0;
  endtask

  initial begin
    reset = 1'b0; UART_RX = 1'b1; rx_enable = 1'b1; rd_en = 1'b0;
    idle(3);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_valid", rx_valid, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_irq", irq, 0);
    reset = 1'b1;
    idle(10);

    send(8'h5A, 1'b1, 640, -1);
    chk("5a_lat_before", v_before, 0);
    chk("5a_lat_after", v_after, 1);
    chk("5a_data", rx_data, 8'h5A);
    chk("5a_ferr", frame_err, 0);
    chk("5a_ovr", overrun, 0);
    chk("5a_irq", irq, 1);
    idle(10);

    UART_RX = 1'b0;
    idle(20);
    UART_RX = 1'b1;
    idle(100);
    chk("glitch_valid", rx_valid, 1);
    chk("glitch_data", rx_data, 8'h5A);
    chk("glitch_ferr", frame_err, 0);

    // Frame error with rd_en on the same edge; line then stays low.
    send(8'hA5, 1'b0, 640, 610);
    chk("a5_ferr", frame_err, 1);
    chk("a5_valid", rx_valid, 0);
    chk("a5_data", rx_data, 8'h5A);
    chk("a5_irq", irq, 1);
    pulse_rd();
    chk("a5_ferr_clr", frame_err, 0);
    chk("a5_irq_clr", irq, 0);
    idle(700);
    chk("low_hold_ferr", frame_err, 0);
    chk("low_hold_valid", rx_valid, 0);
    UART_RX = 1'b1;
    idle(20);

    send(8'h11, 1'b1, 640, -1);
    idle(10);
    send(8'h22, 1'b1, 640, -1);
    chk("ovr_data", rx_data, 8'h22);
    chk("ovr_valid", rx_valid, 1);
    chk("ovr_flag", overrun, 1);
    chk("ovr_irq", irq, 1);
    pulse_rd();
    chk("ovr_clr", overrun, 0);
    idle(10);
    send(8'h11, 1'b1, 640, -1);
    idle(10);
    send(8'h22, 1'b1, 640, 610);
    chk("rdc_data", rx_data, 8'h22);
    chk("rdc_valid", rx_valid, 1);
    chk("rdc_ovr", overrun, 0);
    chk("rdc_ferr", frame_err, 0);
    idle(10);

    send(8'hFF, 1'b1, 280, -1);
    reset = 1'b0;
    idle(1);
    chk("mrst_data", rx_data, 8'h00);
    chk("mrst_valid", rx_valid, 0);
    chk("mrst_ferr", frame_err, 0);
    chk("mrst_ovr", overrun, 0);
    chk("mrst_irq", irq, 0);
    reset = 1'b1;
    idle(700);
    chk("mrst_no_byte", rx_valid, 0);
    send(8'h3C, 1'b1, 640, -1);
    chk("3c_lat_before", v_before, 0);
    chk("3c_lat_after", v_after, 1);
    chk("3c_data", rx_data, 8'h3C);
    idle(10);

    pulse_rd();
    send(8'hC3, 1'b1, 350, -1);
    rx_enable = 1'b0;
    UART_RX = 1'b1;
    idle(700);
    chk("abort_valid", rx_valid, 0);
    chk("abort_ferr", frame_err, 0);
    chk("abort_ovr", overrun, 0);
    chk("abort_data", rx_data, 8'h3C);
    rx_enable = 1'b1;
    idle(10);
    send(8'h81, 1'b1, 640, -1);
    chk("81_data", rx_data, 8'h81);
    chk("81_valid", rx_valid, 1);
    chk("81_ovr", overrun, 0);
    chk("81_ferr", frame_err, 0);
    idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
